// File: rtl/sys_clkgen_if.sv
// Configuration handshake bundle for sys_clkgen: one valid/ready transfer
// carries a channel select (or broadcast flag), a divide ratio and a phase.
interface sys_clkgen_if #(
    parameter int CH_W  = 2,
    parameter int DIV_W = 16
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic             cfg_all;
    logic [CH_W-1:0]  cfg_ch;
    logic [DIV_W-1:0] cfg_div;
    logic [DIV_W-1:0] cfg_phase;

    modport master (
        output cfg_valid, cfg_all, cfg_ch, cfg_div, cfg_phase,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_all, cfg_ch, cfg_div, cfg_phase,
        output cfg_ready
    );
endinterface

// File: rtl/sys_clkgen.sv
// Multi-channel divided clock / clock-enable generator with runtime
// reprogramming and a settle counter that reports lock.
module sys_clkgen #(
    parameter int NUM_CH      = 3,
    parameter int DIV_W       = 16,
    parameter int DEF_DIV     = 4,
    parameter int LOCK_CYCLES = 1024,
    parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst,
    sys_clkgen_if.slave       cfg,
    output logic [NUM_CH-1:0] outclk,
    output logic [NUM_CH-1:0] outce,
    output logic              locked
);
    localparam int SET_W = $clog2(LOCK_CYCLES);

    typedef enum logic [1:0] {SETTLE, LOCKED, APPLY} state_t;

    state_t            state_reg;
    state_t            state_next;
    logic              xfer;
    logic              apply_en;
    logic              settle_done;
    logic [SET_W-1:0]  settle_reg;
    logic              locked_reg;

    logic              apply_all_reg;
    logic [CH_W-1:0]   apply_ch_reg;
    logic [DIV_W-1:0]  apply_div_reg;
    logic [DIV_W-1:0]  apply_phase_reg;
    logic [DIV_W-1:0]  load_cnt;

    // N=1 is a constant-high clock; N=0 decodes to all zeros because c < 0 never holds.
    function automatic logic clk_of(input logic [DIV_W-1:0] c, input logic [DIV_W-1:0] n);
        return (n == DIV_W'(1)) || (c < (n >> 1));
    endfunction

    function automatic logic ce_of(input logic [DIV_W-1:0] c, input logic [DIV_W-1:0] n);
        return (n != '0) && (c == '0);
    endfunction

    assign settle_done = (settle_reg == SET_W'(LOCK_CYCLES - 1));
    assign xfer        = cfg.cfg_valid && cfg.cfg_ready;
    assign load_cnt    = (apply_phase_reg < apply_div_reg) ? apply_phase_reg : '0;

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_reg <= SETTLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            SETTLE: begin
                if (xfer) begin
                    state_next = APPLY;
                end else if (settle_done) begin
                    state_next = LOCKED;
                end
            end
            LOCKED: begin
                if (xfer) begin
                    state_next = APPLY;
                end
            end
            APPLY:   state_next = SETTLE;
            default: state_next = SETTLE;
        endcase
    end

    always_comb begin
        cfg.cfg_ready = (state_reg != APPLY) && !rst;
        apply_en      = (state_reg == APPLY);
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            apply_all_reg   <= 1'b0;
            apply_ch_reg    <= '0;
            apply_div_reg   <= '0;
            apply_phase_reg <= '0;
        end else if (xfer) begin
            apply_all_reg   <= cfg.cfg_all;
            apply_ch_reg    <= cfg.cfg_ch;
            apply_div_reg   <= cfg.cfg_div;
            apply_phase_reg <= cfg.cfg_phase;
        end
    end

    // A transfer on the very edge settle completes wins: no one-cycle lock blip.
    always_ff @(posedge refclk) begin
        if (rst || apply_en) begin
            settle_reg <= '0;
            locked_reg <= 1'b0;
        end else if (state_reg == SETTLE && !xfer) begin
            if (settle_done) begin
                locked_reg <= 1'b1;
            end else begin
                settle_reg <= settle_reg + SET_W'(1);
            end
        end
    end

    assign locked = locked_reg;

    logic [DIV_W-1:0] div_reg    [NUM_CH];
    logic [DIV_W-1:0] cnt_reg    [NUM_CH];
    logic [DIV_W-1:0] cnt_next   [NUM_CH];
    logic             outclk_reg [NUM_CH];
    logic             outce_reg  [NUM_CH];
    logic             hit        [NUM_CH];

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign hit[gi] = apply_en && (apply_all_reg || (apply_ch_reg == CH_W'(gi)));

            always_comb begin
                cnt_next[gi] = '0;
                if (div_reg[gi] > DIV_W'(1) && cnt_reg[gi] != div_reg[gi] - DIV_W'(1)) begin
                    cnt_next[gi] = cnt_reg[gi] + DIV_W'(1);
                end
            end

            always_ff @(posedge refclk) begin
                if (rst) begin
                    div_reg[gi]    <= DIV_W'(DEF_DIV);
                    cnt_reg[gi]    <= DIV_W'(DEF_DIV - 1);
                    outclk_reg[gi] <= 1'b0;
                    outce_reg[gi]  <= 1'b0;
                end else if (hit[gi]) begin
                    div_reg[gi]    <= apply_div_reg;
                    cnt_reg[gi]    <= load_cnt;
                    outclk_reg[gi] <= clk_of(load_cnt, apply_div_reg);
                    outce_reg[gi]  <= ce_of(load_cnt, apply_div_reg);
                end else begin
                    cnt_reg[gi]    <= cnt_next[gi];
                    outclk_reg[gi] <= clk_of(cnt_next[gi], div_reg[gi]);
                    outce_reg[gi]  <= ce_of(cnt_next[gi], div_reg[gi]);
                end
            end

            assign outclk[gi] = outclk_reg[gi];
            assign outce[gi]  = outce_reg[gi];
        end
    endgenerate
endmodule

// File: tb/tb_sys_clkgen.sv
// Randomised scoreboard bench for sys_clkgen: a phase-arithmetic model pushes
// the expected outputs each edge, a negedge monitor pops and compares.
module tb_sys_clkgen;
    localparam int NUM_CH = 3;
    localparam int DIV_W  = 16;
    localparam int DEFD   = 4;
    localparam int LOCKC  = 16;
    localparam int CH_W   = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NUM_CH-1:0] outclk;
    logic [NUM_CH-1:0] outce;
    logic              locked;

    sys_clkgen_if #(.CH_W(CH_W), .DIV_W(DIV_W)) cfg ();

    sys_clkgen #(
        .NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEF_DIV(DEFD), .LOCK_CYCLES(LOCKC)
    ) dut (
        .refclk(clk),
        .rst(rst),
        .cfg(cfg),
        .outclk(outclk),
        .outce(outce),
        .locked(locked)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NUM_CH-1:0] ck;
        logic [NUM_CH-1:0] ce;
        logic              lck;
        logic              pend;
        int                e;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: each channel is described by ratio n, and the edge org
    // at which its position in the period equals ph.
    int   e = 0;
    int   m_n   [NUM_CH];
    int   m_org [NUM_CH];
    int   m_ph  [NUM_CH];
    int   lock_org = 0;
    bit   m_locked = 0;
    bit   m_pend   = 0;
    bit   m_acc    = 0;
    bit   l_all;
    int   l_ch, l_div, l_ph;

    always @(posedge clk) begin
        exp_t x;
        bit   rst_edge;
        e++;
        m_acc    = 0;
        rst_edge = rst;
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_n[i] = DEFD; m_org[i] = e + 1; m_ph[i] = 0;
            end
            lock_org = e; m_locked = 0; m_pend = 0;
        end else if (m_pend) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (l_all || l_ch == i) begin
                    m_n[i] = l_div; m_org[i] = e;
                    m_ph[i] = (l_ph < l_div) ? l_ph : 0;
                end
            end
            lock_org = e; m_locked = 0; m_pend = 0;
        end else if (cfg.cfg_valid) begin
            m_acc = 1; m_pend = 1;
            l_all = cfg.cfg_all; l_ch = int'(cfg.cfg_ch);
            l_div = int'(cfg.cfg_div); l_ph = int'(cfg.cfg_phase);
        end else if (!m_locked && e == lock_org + LOCKC) begin
            m_locked = 1;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            int pos;
            pos = (m_n[i] == 0) ? 0 : (m_ph[i] + e - m_org[i]) % m_n[i];
            x.ck[i] = !rst_edge && (m_n[i] == 1 || (m_n[i] >= 2 && pos < m_n[i] / 2));
            x.ce[i] = !rst_edge && m_n[i] != 0 && pos == 0;
        end
        x.lck  = m_locked;
        x.pend = m_pend;
        x.e    = e;
        sb.push_back(x);
    end

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t x;
            logic exp_rdy;
            x = sb.pop_front();
            exp_rdy = !x.pend && !rst;
            total++;
            if (outclk !== x.ck || outce !== x.ce || locked !== x.lck || cfg.cfg_ready !== exp_rdy) begin
                bad++;
                $display("FAIL edge%0d outputs: outclk=%b want %b outce=%b want %b locked=%b want %b ready=%b want %b",
                         x.e, outclk, x.ck, outce, x.ce, locked, x.lck, cfg.cfg_ready, exp_rdy);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input bit all, input logic [CH_W-1:0] ch,
                        input logic [DIV_W-1:0] dv, input logic [DIV_W-1:0] ph);
        bit done;
        done = 0;
        cfg.cfg_valid = 1'b1; cfg.cfg_all = all; cfg.cfg_ch = ch;
        cfg.cfg_div = dv; cfg.cfg_phase = ph;
        for (int k = 0; k < 8 && !done; k++) begin
            tick(1);
            done = m_acc;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL cfg_accept: got no transfer, want one within 8 cycles");
        end
        $display("cfg edge%0d all=%0b ch=%0d div=%0d phase=%0d", e, all, ch, dv, ph);
        cfg.cfg_valid = 1'b0;
    endtask

    initial begin
        cfg.cfg_valid = 1'b0; cfg.cfg_all = 1'b0; cfg.cfg_ch = '0;
        cfg.cfg_div = '0; cfg.cfg_phase = '0;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(24);
        send(1'b0, 2'd1, 16'd5, 16'd0);   tick(30);
        send(1'b1, 2'd0, 16'd3, 16'd2);   tick(24);
        send(1'b0, 2'd2, 16'd1, 16'd0);   tick(24);
        send(1'b0, 2'd2, 16'd0, 16'd0);   tick(24);
        send(1'b0, 2'd0, 16'd6, 16'd1);   tick(5);
        send(1'b0, 2'd3, 16'd7, 16'd0);   tick(24);
        send(1'b0, 2'd1, 16'd2, 16'd0);
        send(1'b0, 2'd0, 16'd7, 16'd3);   tick(24);
        send(1'b1, 2'd0, 16'd6, 16'd0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(10);
        send(1'b0, 2'd0, 16'd4, 16'd7);   tick(22);
        for (int t = 0; t < 60; t++) begin
            tick($urandom_range(0, 30));
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1;
                tick($urandom_range(1, 2));
                rst = 1'b0;
                $display("rst pulse ending edge%0d", e);
            end else begin
                send($urandom_range(0, 3) == 0, CH_W'($urandom_range(0, 3)),
                     DIV_W'($urandom_range(0, 9)), DIV_W'($urandom_range(0, 12)));
            end
        end
        tick(20);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
